// File: rtl/adc_init_sequencer.sv
// rtl/adc_init_sequencer.sv - power-up SPI configuration sequencer for the external ADC
module adc_init_sequencer #(
    parameter int CLK_DIV       = 4,
    parameter int POWERUP_TICKS = 1000,
    parameter int N_WORDS       = 8,
    parameter int ADDR_W        = 3,
    parameter int CS_GAP_TICKS  = 8
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_restart,
    output logic [ADDR_W-1:0] o_cfg_addr,
    input  logic [15:0]       i_cfg_data,
    output logic              o_spi_cs_n,
    output logic              o_spi_sclk,
    output logic              o_spi_mosi,
    output logic              o_busy,
    output logic              o_adc_init_done
);

    localparam logic [31:0]       PWR_LAST = 32'(POWERUP_TICKS - 1);
    localparam logic [31:0]       DIV_LAST = 32'(CLK_DIV - 1);
    localparam logic [31:0]       GAP_LAST = 32'(CS_GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_POWERUP,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;      // 0..15 = bits on the wire, 16 = trailing hold phase
    logic [14:0]       shreg_q, shreg_d;  // bits still to be sent; bit 15 goes straight to MOSI
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              cs_n_q, cs_n_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    assign o_cfg_addr      = idx_q;
    assign o_spi_cs_n      = cs_n_q;
    assign o_spi_sclk      = sclk_q;
    assign o_spi_mosi      = mosi_q;
    assign o_busy          = busy_q;
    assign o_adc_init_done = done_q;

    // State and output registers; reset drops CS and SCLK to idle without a clock.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_POWERUP;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic for the power-up / fetch / shift / gap sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            S_POWERUP: begin
                busy_d = 1'b1;
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FETCH: begin
                // Address is already on o_cfg_addr; the ROM answers next cycle.
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d = i_cfg_data[14:0];
                mosi_d  = i_cfg_data[15];
                cs_n_d  = 1'b0;
                bit_d   = '0;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd16) begin
                        // Hold phase over: release CS with SCLK already low.
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = S_GAP;
                    end else if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance MOSI except after bit0, which is held.
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                        if (bit_q != 5'd15) begin
                            mosi_d  = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                if (i_restart) begin
                    state_d = S_POWERUP;
                    cnt_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_POWERUP;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_init_sequencer.sv
// tb/tb_adc_init_sequencer.sv - self-checking bench for adc_init_sequencer
module tb_adc_init_sequencer;

    localparam int CD_A = 2, PWR_A = 10, N_A = 3, AW_A = 2, GAP_A = 8;
    localparam int CD_B = 1, PWR_B = 4, N_B = 1, AW_B = 1, GAP_B = 1;

    typedef struct packed {
        logic [15:0] word;
        int          rises;
        int          cs_len;
        int          gap;
        int          end_cyc;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a_n = 1'b0, restart_a = 1'b0;
    logic [AW_A-1:0] addr_a;
    logic [15:0]     data_a;
    logic            cs_a, sclk_a, mosi_a, busy_a, done_a;

    logic            rst_b_n = 1'b0, restart_b = 1'b0;
    logic [AW_B-1:0] addr_b;
    logic [15:0]     data_b;
    logic            cs_b, sclk_b, mosi_b, busy_b, done_b;

    logic [15:0] cfg_a [0:3] = '{16'hA5F0, 16'h1234, 16'hFFFF, 16'h0000};
    logic [15:0] cfg_b [0:1] = '{16'h8001, 16'h0000};

    always @(posedge clk) data_a <= cfg_a[addr_a];
    always @(posedge clk) data_b <= cfg_b[addr_b];

    adc_init_sequencer #(.CLK_DIV(CD_A), .POWERUP_TICKS(PWR_A), .N_WORDS(N_A),
                         .ADDR_W(AW_A), .CS_GAP_TICKS(GAP_A)) dut_a (
        .i_clock(clk), .i_reset_n(rst_a_n), .i_restart(restart_a),
        .o_cfg_addr(addr_a), .i_cfg_data(data_a),
        .o_spi_cs_n(cs_a), .o_spi_sclk(sclk_a), .o_spi_mosi(mosi_a),
        .o_busy(busy_a), .o_adc_init_done(done_a));

    adc_init_sequencer #(.CLK_DIV(CD_B), .POWERUP_TICKS(PWR_B), .N_WORDS(N_B),
                         .ADDR_W(AW_B), .CS_GAP_TICKS(GAP_B)) dut_b (
        .i_clock(clk), .i_reset_n(rst_b_n), .i_restart(restart_b),
        .o_cfg_addr(addr_b), .i_cfg_data(data_b),
        .o_spi_cs_n(cs_b), .o_spi_sclk(sclk_b), .o_spi_mosi(mosi_b),
        .o_busy(busy_b), .o_adc_init_done(done_b));

    int tests_run = 0;
    int fails     = 0;
    int cyc       = 0;
    int glitches  = 0;
    int mon_rises = 0;
    logic [15:0] exp_q [$];
    frame_t      got_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Frame monitor for dut_a: rebuilds each word from MOSI at SCLK rises.
    bit          in_frame = 1'b0;
    logic [15:0] cur_word;
    int          cur_len, cur_gap, hi_cnt;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (!rst_a_n) begin
            in_frame = 1'b0; mon_rises = 0; hi_cnt = 0;
            prev_cs = 1'b1; prev_sclk = 1'b0;
        end else begin
            if (cs_a !== prev_cs && (sclk_a !== 1'b0 || prev_sclk !== 1'b0)) glitches++;
            if (cs_a === 1'b0) begin
                if (!in_frame) begin
                    in_frame = 1'b1; cur_word = '0; mon_rises = 0; cur_len = 0; cur_gap = hi_cnt;
                end
                cur_len++;
                if (sclk_a === 1'b1 && prev_sclk === 1'b0) begin
                    cur_word = {cur_word[14:0], mosi_a};
                    mon_rises++;
                end
            end else begin
                if (in_frame) begin
                    got_q.push_back('{cur_word, mon_rises, cur_len, cur_gap, cyc});
                    in_frame = 1'b0; hi_cnt = 0;
                end
                hi_cnt++;
            end
            prev_cs = cs_a; prev_sclk = sclk_a;
        end
    end

    task automatic wait_frame(output frame_t f, output bit ok);
        int t = 0;
        while (got_q.size() == 0 && t < 2000) begin @(negedge clk); t++; end
        ok = (got_q.size() != 0);
        if (ok) f = got_q.pop_front();
        else    f = '0;
    endtask

    task automatic test_reset();
        int n;
        rst_a_n = 1'b0; restart_a = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({cs_a, sclk_a, mosi_a, done_a, busy_a} !== 5'b10000) begin
            fails++; $display("FAIL reset_outputs: got %b required 10000", {cs_a, sclk_a, mosi_a, done_a, busy_a});
        end
        tests_run++;
        if (addr_a !== '0) begin fails++; $display("FAIL reset_addr: got %0d required 0", addr_a); end
        for (int i = 0; i < N_A; i++) exp_q.push_back(cfg_a[i]);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_after_release: got %b required 1", busy_a); end
        n = 0;
        while (cs_a === 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (cs_a !== 1'b0 || n < PWR_A || n > PWR_A + 2) begin
            fails++; $display("FAIL powerup_cs_high: got %0d cycles required %0d..%0d", n, PWR_A, PWR_A + 2);
        end
        tests_run++;
        if (addr_a !== '0) begin fails++; $display("FAIL first_addr: got %0d required 0", addr_a); end
    endtask

    task automatic test_frame0();
        frame_t f; bit ok; logic [15:0] e;
        wait_frame(f, ok);
        tests_run++;
        if (!ok) begin fails++; $display("FAIL frame0_timeout: got none required 1 frame"); return; end
        e = exp_q.pop_front();
        tests_run++;
        if (f.word !== e) begin fails++; $display("FAIL frame0_word: got %h required %h", f.word, e); end
        tests_run++;
        if (f.rises !== 16) begin fails++; $display("FAIL frame0_rises: got %0d required 16", f.rises); end
        tests_run++;
        if (f.cs_len !== 33 * CD_A) begin fails++; $display("FAIL frame0_cs_len: got %0d required %0d", f.cs_len, 33 * CD_A); end
        tests_run++;
        if (glitches !== 0) begin fails++; $display("FAIL frame0_sclk_at_cs_edge: got %0d required 0", glitches); end
    endtask

    task automatic test_full_sequence();
        frame_t f; bit ok; logic [15:0] e; int n; logic pb;
        for (int i = 1; i < N_A; i++) begin
            wait_frame(f, ok);
            tests_run++;
            if (!ok) begin fails++; $display("FAIL seq_timeout: frame %0d missing", i); return; end
            e = exp_q.pop_front();
            tests_run++;
            if (f.word !== e) begin fails++; $display("FAIL seq_word%0d: got %h required %h", i, f.word, e); end
            tests_run++;
            if (f.rises !== 16 || f.cs_len !== 33 * CD_A) begin
                fails++; $display("FAIL seq_shape%0d: got %0d rises %0d cs required 16 %0d", i, f.rises, f.cs_len, 33 * CD_A);
            end
            tests_run++;
            if (f.gap < GAP_A) begin fails++; $display("FAIL seq_gap%0d: got %0d required >= %0d", i, f.gap, GAP_A); end
        end
        n = 0; pb = busy_a;
        while (done_a !== 1'b1 && n < 200) begin pb = busy_a; @(negedge clk); n++; end
        tests_run++;
        if (done_a !== 1'b1) begin fails++; $display("FAIL seq_done: got %b required 1", done_a); end
        tests_run++;
        if (busy_a !== 1'b0 || pb !== 1'b1) begin
            fails++; $display("FAIL seq_busy_fall: got before %b at done %b required 1 0", pb, busy_a);
        end
        tests_run++;
        if (cyc - f.end_cyc !== GAP_A) begin
            fails++; $display("FAIL seq_done_latency: got %0d required %0d", cyc - f.end_cyc, GAP_A);
        end
        tests_run++;
        if (glitches !== 0) begin fails++; $display("FAIL seq_sclk_at_cs_edge: got %0d required 0", glitches); end
    endtask

    task automatic test_restart();
        frame_t f; bit ok; logic [15:0] e; int n;
        for (int i = 0; i < N_A; i++) exp_q.push_back(cfg_a[i]);
        @(negedge clk); restart_a = 1'b1;
        @(negedge clk); restart_a = 1'b0;
        tests_run++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            fails++; $display("FAIL restart_flags: got done %b busy %b required 0 1", done_a, busy_a);
        end
        for (int i = 0; i < N_A; i++) begin
            wait_frame(f, ok);
            tests_run++;
            if (!ok) begin fails++; $display("FAIL restart_timeout: frame %0d missing", i); return; end
            e = exp_q.pop_front();
            tests_run++;
            if (f.word !== e || f.rises !== 16 || f.cs_len !== 33 * CD_A) begin
                fails++; $display("FAIL restart_frame%0d: got %h/%0d/%0d required %h/16/%0d", i, f.word, f.rises, f.cs_len, e, 33 * CD_A);
            end
            if (i == 0) begin
                n = 0;
                while (cs_a !== 1'b0 && n < 200) begin @(negedge clk); n++; end
                restart_a = 1'b1;
                @(negedge clk); restart_a = 1'b0;
                tests_run++;
                if (cs_a !== 1'b0 || busy_a !== 1'b1) begin
                    fails++; $display("FAIL restart_ignored: got cs %b busy %b required 0 1", cs_a, busy_a);
                end
            end
        end
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        tests_run++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || exp_q.size() != 0) begin
            fails++; $display("FAIL restart_done: got done %b busy %b left %0d required 1 0 0", done_a, busy_a, exp_q.size());
        end
    endtask

    task automatic test_mid_frame_reset();
        frame_t f; bit ok; logic [15:0] e; int n;
        for (int i = 0; i < N_A; i++) exp_q.push_back(cfg_a[i]);
        @(negedge clk); restart_a = 1'b1;
        @(negedge clk); restart_a = 1'b0;
        wait_frame(f, ok);
        e = exp_q.pop_front();
        tests_run++;
        if (!ok || f.word !== e) begin fails++; $display("FAIL midrst_frame0: got %h required %h", f.word, e); end
        n = 0;
        while (!(cs_a === 1'b0 && mon_rises == 7) && n < 400) begin @(negedge clk); n++; end
        tests_run++;
        if (n >= 400) begin fails++; $display("FAIL midrst_bit7_timeout: got none required bit 7 of frame 1"); end
        @(posedge clk); #2;
        rst_a_n = 1'b0;
        #1;
        tests_run++;
        if ({cs_a, sclk_a, done_a, busy_a} !== 4'b1000) begin
            fails++; $display("FAIL midrst_async: got %b required 1000", {cs_a, sclk_a, done_a, busy_a});
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        for (int i = 0; i < N_A; i++) exp_q.push_back(cfg_a[i]);
        rst_a_n = 1'b1;
        n = 0;
        while (cs_a !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (n < PWR_A || addr_a !== '0) begin
            fails++; $display("FAIL midrst_powerup: got %0d cycles addr %0d required >= %0d addr 0", n, addr_a, PWR_A);
        end
        for (int i = 0; i < N_A; i++) begin
            wait_frame(f, ok);
            e = exp_q.pop_front();
            tests_run++;
            if (!ok || f.word !== e || f.rises !== 16 || f.cs_len !== 33 * CD_A) begin
                fails++; $display("FAIL midrst_frame%0d: got %h/%0d/%0d required %h/16/%0d", i, f.word, f.rises, f.cs_len, e, 33 * CD_A);
            end
        end
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        tests_run++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            fails++; $display("FAIL midrst_done: got done %b busy %b required 1 0", done_a, busy_a);
        end
    endtask

    task automatic test_divider_corner();
        logic [15:0] w, e; int n, rises, len, tog; logic prev;
        exp_q.push_back(cfg_b[0]);
        @(negedge clk); rst_b_n = 1'b1;
        n = 0;
        while (cs_b !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        w = '0; rises = 0; len = 0; tog = 0; prev = 1'b0;
        while (cs_b === 1'b0 && len < 200) begin
            if (sclk_b === 1'b1 && prev === 1'b0) begin w = {w[14:0], mosi_b}; rises++; end
            if (sclk_b !== prev) tog++;
            prev = sclk_b; len++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (w !== e) begin fails++; $display("FAIL div1_word: got %h required %h", w, e); end
        tests_run++;
        if (rises !== 16 || len !== 33) begin
            fails++; $display("FAIL div1_shape: got %0d rises %0d cs required 16 33", rises, len);
        end
        tests_run++;
        if (tog !== 32) begin fails++; $display("FAIL div1_toggles: got %0d required 32", tog); end
        n = 0;
        while (done_b !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (done_b !== 1'b1 || busy_b !== 1'b0) begin
            fails++; $display("FAIL div1_done: got done %b busy %b required 1 0", done_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_frame0();
        test_full_sequence();
        test_restart();
        test_mid_frame_reset();
        test_divider_corner();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
